// File: rtl/mr_fetch.sv
// mr_fetch: sequential PC fetch, in-order imem request/response,
// fetch queue to decode with retire-slot allocation and flush redirect.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_req_valid/ready/addr fetch request channel
//   imem_resp_valid/data      in-order response channel, no backpressure
//   wb_full, wb_next_id       retire queue status and free slot id
//   wb_inst_in, wb_inst_pc    retire slot allocation
//   flush_pipe_to_pc/flush_pc redirect from writeback
//   dec_valid/ready/inst/pc/id decode handshake and payload
module mr_fetch #(
  parameter int XLEN = 32,
  parameter int INSTID_BITS = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  input  logic                   wb_full,
  input  logic [INSTID_BITS-1:0] wb_next_id,
  output logic                   wb_inst_in,
  output logic [XLEN-1:0]        wb_inst_pc,
  input  logic                   flush_pipe_to_pc,
  input  logic [XLEN-1:0]        flush_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [31:0]            dec_inst,
  output logic [XLEN-1:0]        dec_pc,
  output logic [INSTID_BITS-1:0] dec_id
);

  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fq_ent_t;

  fq_ent_t         fq_mem [FQ_DEPTH];
  logic [XLEN-1:0] rq_pc  [FQ_DEPTH];

  logic [XLEN-1:0] pc;
  logic [AW-1:0]   fq_head, fq_tail;
  logic [AW-1:0]   rq_head, rq_tail;
  logic [CW-1:0]   fq_count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   live;
  logic [CW:0]     credit;
  logic            can_req;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            unused_flush_lsb;

  assign unused_flush_lsb = ^flush_pc[1:0];

  // Credit counts live requests as already occupying a queue slot,
  // so a returning word always has room.
  always_comb begin
    live    = outstanding - drop_cnt;
    credit  = {1'b0, live} + {1'b0, fq_count};
    can_req = (credit < DEPTH_W) && (outstanding < DEPTH_C);
  end

  assign imem_req_valid = !rst && can_req && !flush_pipe_to_pc;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_resp_valid && !flush_pipe_to_pc
             && (drop_cnt == '0);

  assign dec_valid  = (fq_count != '0) && !wb_full
                   && !flush_pipe_to_pc;
  assign dec_inst   = fq_mem[fq_head].inst;
  assign dec_pc     = fq_mem[fq_head].pc;
  assign dec_id     = wb_next_id;
  assign pop        = dec_valid && dec_ready;
  assign wb_inst_in = pop;
  assign wb_inst_pc = dec_pc;

  // Storage only; validity is carried by the reset pointers.
  always_ff @(posedge clk) begin
    if (req_fire)
      rq_pc[rq_tail] <= pc;
    if (push)
      fq_mem[fq_tail] <= '{inst: imem_resp_data,
                           pc:   rq_pc[rq_head]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      fq_head     <= '0;
      fq_tail     <= '0;
      fq_count    <= '0;
      rq_head     <= '0;
      rq_tail     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (req_fire) begin
        pc      <= pc + XLEN'(4);
        rq_tail <= rq_tail + AW'(1);
      end
      // The request PC FIFO tracks doomed requests too, so it
      // keeps popping on every response across flushes.
      if (imem_resp_valid)
        rq_head <= rq_head + AW'(1);
      unique case ({req_fire, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      if (flush_pipe_to_pc) begin
        pc       <= {flush_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding - CW'(imem_resp_valid);
        fq_head  <= '0;
        fq_tail  <= '0;
        fq_count <= '0;
      end else begin
        if (imem_resp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (push)
          fq_tail <= fq_tail + AW'(1);
        if (pop)
          fq_head <= fq_head + AW'(1);
        unique case ({push, pop})
          2'b10:   fq_count <= fq_count + CW'(1);
          2'b01:   fq_count <= fq_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mr_fetch.sv
// tb_mr_fetch: directed and random tests for mr_fetch against an
// in-order memory model returning addr ^ 0xA5A5A5A5.
module tb_mr_fetch;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req_valid;
  logic        imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        wb_full = 0;
  logic [3:0]  wb_next_id = 0;
  logic        wb_inst_in;
  logic [31:0] wb_inst_pc;
  logic        flush = 0;
  logic [31:0] flush_pc = 0;
  logic        dec_valid;
  logic        dec_ready = 0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [3:0]  dec_id;

  int checks = 0;
  int errors = 0;

  mr_fetch #(
    .XLEN(32), .INSTID_BITS(4),
    .RESET_PC(32'h100), .FQ_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .wb_full(wb_full), .wb_next_id(wb_next_id),
    .wb_inst_in(wb_inst_in), .wb_inst_pc(wb_inst_pc),
    .flush_pipe_to_pc(flush), .flush_pc(flush_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_id(dec_id)
  );

  always #5 clk = ~clk;

  // memory model
  int          mem_lat = 1;
  bit          rand_lat = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mcyc;
  int          lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_resp_valid <= 0;
      imem_resp_data  <= 0;
      mcyc = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        lat = rand_lat ? int'($urandom_range(4, 1)) : mem_lat;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(mcyc + lat - 1);
      end
      imem_resp_valid <= 0;
      if (mq_due.size() != 0 && mq_due[0] <= mcyc) begin
        imem_resp_valid <= 1;
        imem_resp_data  <= mq_addr[0] ^ K;
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      mcyc++;
    end
  end

  // decode log and outstanding tracker
  logic [31:0] dq_pc[$];
  logic [31:0] dq_inst[$];
  logic [3:0]  dq_id[$];
  logic [3:0]  dq_nid[$];
  int out_cnt = 0;
  int max_out = 0;
  int n_dec = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt = 0;
    end else begin
      if (wb_inst_in) begin
        dq_pc.push_back(wb_inst_pc);
        dq_inst.push_back(dec_inst);
        dq_id.push_back(dec_id);
        dq_nid.push_back(wb_next_id);
        n_dec++;
      end
      if (imem_req_valid && imem_req_ready) out_cnt++;
      if (imem_resp_valid) out_cnt--;
      if (out_cnt > max_out) max_out = out_cnt;
    end
  end

  logic [31:0] exp_pc;

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
    end
    checks++;
    if (dec_valid !== 1'b0 || wb_inst_in !== 1'b0) begin
      errors++;
      $display("FAIL rst_dec got %b/%b want 0/0",
               dec_valid, wb_inst_in);
    end
    checks++;
    if (imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL rst_addr got %h want 00000100", imem_req_addr);
    end
  endtask

  task automatic test_startup;
    imem_req_ready = 1;
    dec_ready = 1;
    wb_full = 0;
    mem_lat = 1;
    rst = 0;
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      wb_next_id = 4'(i + 5);
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 ||
          imem_req_addr !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL start_req%0d got %b %h want 1 %h", i,
                 imem_req_valid, imem_req_addr, 32'h100 + 32'(4 * i));
      end
      if (i == 2) begin
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h100 ||
            dec_inst !== 32'hA5A5_A4A5 || dec_id !== 4'd7) begin
          errors++;
          $display("FAIL start_dec got %b %h %h %h want 1 100 a5a5a4a5 7",
                   dec_valid, dec_pc, dec_inst, dec_id);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      wb_next_id = 4'(i + 9);
      @(negedge clk);
    end
    checks++;
    if (dq_pc.size() < 5) begin
      errors++;
      $display("FAIL start_rate got %0d decodes want >=5", dq_pc.size());
    end
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K) ||
          dq_id[0] !== dq_nid[0]) begin
        errors++;
        $display("FAIL start_stream got %h %h %h want %h %h %h",
                 dq_pc[0], dq_inst[0], dq_id[0],
                 exp_pc, exp_pc ^ K, dq_nid[0]);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
  endtask

  task automatic test_backpressure;
    dec_ready = 0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (int'(dut.fq_count) != 4 || imem_req_valid !== 1'b0 ||
        dec_valid !== 1'b1 || out_cnt != 0) begin
      errors++;
      $display("FAIL bp_full got cnt=%0d req=%b dv=%b out=%0d want 4 0 1 0",
               dut.fq_count, imem_req_valid, dec_valid, out_cnt);
    end
    dec_ready = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (dq_pc.size() < 8) begin
      errors++;
      $display("FAIL bp_release got %0d decodes want >=8", dq_pc.size());
    end
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K)) begin
        errors++;
        $display("FAIL bp_stream got %h %h want %h %h",
                 dq_pc[0], dq_inst[0], exp_pc, exp_pc ^ K);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
  endtask

  task automatic test_wb_full;
    wb_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dec_valid !== 1'b0 || wb_inst_in !== 1'b0) begin
        errors++;
        $display("FAIL wbfull_block%0d got %b %b want 0 0",
                 i, dec_valid, wb_inst_in);
      end
      @(negedge clk);
    end
    checks++;
    if (dq_pc.size() != 0) begin
      errors++;
      $display("FAIL wbfull_nolog got %0d want 0", dq_pc.size());
    end
    wb_full = 0;
    #1;
    checks++;
    if (wb_inst_in !== 1'b1 || wb_inst_pc !== exp_pc) begin
      errors++;
      $display("FAIL wbfull_release got %b %h want 1 %h",
               wb_inst_in, wb_inst_pc, exp_pc);
    end
    @(negedge clk);
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K)) begin
        errors++;
        $display("FAIL wbfull_stream got %h %h want %h %h",
                 dq_pc[0], dq_inst[0], exp_pc, exp_pc ^ K);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
  endtask

  task automatic test_flush;
    imem_req_ready = 0;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (dec_valid !== 1'b0 || out_cnt != 0) begin
      errors++;
      $display("FAIL flush_idle got dv=%b out=%0d want 0 0",
               dec_valid, out_cnt);
    end
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc) begin
        errors++;
        $display("FAIL flush_pre got %h want %h", dq_pc[0], exp_pc);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
    mem_lat = 3;
    imem_req_ready = 1;
    repeat (2) @(negedge clk);
    flush = 1;
    flush_pc = 32'h2003;
    #1;
    checks++;
    if (out_cnt != 2 || imem_req_valid !== 1'b0 ||
        dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got out=%0d req=%b dv=%b want 2 0 0",
               out_cnt, imem_req_valid, dec_valid);
    end
    @(negedge clk);
    flush = 0;
    #1;
    checks++;
    if (int'(dut.drop_cnt) != 2) begin
      errors++;
      $display("FAIL flush_drop got %0d want 2", dut.drop_cnt);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin
      errors++;
      $display("FAIL flush_req got %b %h want 1 00002000",
               imem_req_valid, imem_req_addr);
    end
    exp_pc = 32'h2000;
    repeat (15) @(negedge clk);
    checks++;
    if (dq_pc.size() == 0 || dq_pc[0] !== 32'h2000) begin
      errors++;
      $display("FAIL flush_first got n=%0d pc=%h want 00002000",
               dq_pc.size(), dq_pc.size() ? dq_pc[0] : 32'h0);
    end
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K)) begin
        errors++;
        $display("FAIL flush_stream got %h %h want %h %h",
                 dq_pc[0], dq_inst[0], exp_pc, exp_pc ^ K);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
  endtask

  task automatic test_flush_collision;
    int exp_drop;
    bit found;
    mem_lat = 2;
    found = 0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (imem_resp_valid && dec_valid && dec_ready && out_cnt >= 2)
        found = 1;
      else
        @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL coll_setup got no collision cycle want one");
    end
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc) begin
        errors++;
        $display("FAIL coll_pre got %h want %h", dq_pc[0], exp_pc);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
    exp_drop = out_cnt - 1;
    flush = 1;
    flush_pc = 32'h3000;
    #1;
    checks++;
    if (wb_inst_in !== 1'b0 || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_noissue got %b %b want 0 0",
               wb_inst_in, dec_valid);
    end
    @(negedge clk);
    flush = 0;
    #1;
    checks++;
    if (int'(dut.drop_cnt) != exp_drop || dq_pc.size() != 0) begin
      errors++;
      $display("FAIL coll_drop got %0d log=%0d want %0d 0",
               dut.drop_cnt, dq_pc.size(), exp_drop);
    end
    exp_pc = 32'h3000;
    repeat (15) @(negedge clk);
    checks++;
    if (dq_pc.size() == 0) begin
      errors++;
      $display("FAIL coll_resume got 0 decodes want >0");
    end
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K)) begin
        errors++;
        $display("FAIL coll_stream got %h %h want %h %h",
                 dq_pc[0], dq_inst[0], exp_pc, exp_pc ^ K);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
  endtask

  task automatic test_random;
    int start_dec;
    rand_lat = 1;
    start_dec = n_dec;
    for (int c = 0; c < 800; c++) begin
      while (dq_pc.size() != 0) begin
        checks++;
        if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K) ||
            dq_id[0] !== dq_nid[0]) begin
          errors++;
          $display("FAIL rand_stream got %h %h %h want %h %h %h",
                   dq_pc[0], dq_inst[0], dq_id[0],
                   exp_pc, exp_pc ^ K, dq_nid[0]);
        end
        exp_pc += 4;
        void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
        void'(dq_id.pop_front()); void'(dq_nid.pop_front());
      end
      imem_req_ready = ($urandom_range(3, 0) != 0);
      dec_ready = 1'($urandom_range(1, 0));
      wb_full = ($urandom_range(7, 0) == 0);
      wb_next_id = 4'($urandom);
      flush = ($urandom_range(30, 0) == 0);
      if ($urandom_range(7, 0) == 0)
        flush_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else
        flush_pc = $urandom;
      if (flush) exp_pc = {flush_pc[31:2], 2'b00};
      #1;
      if (flush) begin
        checks++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_flush got %b %b want 0 0",
                   dec_valid, imem_req_valid);
        end
      end
      if (imem_req_valid) begin
        checks++;
        if (imem_req_addr[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL rand_align got %h want low bits 0",
                   imem_req_addr);
        end
      end
      @(negedge clk);
    end
    flush = 0;
    imem_req_ready = 1;
    dec_ready = 1;
    wb_full = 0;
    repeat (20) @(negedge clk);
    while (dq_pc.size() != 0) begin
      checks++;
      if (dq_pc[0] !== exp_pc || dq_inst[0] !== (exp_pc ^ K)) begin
        errors++;
        $display("FAIL rand_tail got %h %h want %h %h",
                 dq_pc[0], dq_inst[0], exp_pc, exp_pc ^ K);
      end
      exp_pc += 4;
      void'(dq_pc.pop_front()); void'(dq_inst.pop_front());
      void'(dq_id.pop_front()); void'(dq_nid.pop_front());
    end
    checks++;
    if (max_out > 4) begin
      errors++;
      $display("FAIL rand_outstanding got %0d want <=4", max_out);
    end
    checks++;
    if (n_dec - start_dec < 100) begin
      errors++;
      $display("FAIL rand_progress got %0d decodes want >=100",
               n_dec - start_dec);
    end
  endtask

  initial begin
    test_reset;
    test_startup;
    test_backpressure;
    test_wb_full;
    test_flush;
    test_flush_collision;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mr_fetch.md
# mr_fetch

Instruction fetch and issue front end for the mr core. Generates sequential PCs, requests instruction words from instruction memory over a valid/ready request plus in-order response channel, and buffers returned words in a small fetch queue. It hands them to decode with a valid/ready handshake, allocating a retire-queue slot in the writeback unit in the same cycle. It redirects on writeback's pipe-flush request and discards stale in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, default `XLEN'h0`: first fetch address after reset.
- `FQ_DEPTH`, default 2: fetch queue entries; also the cap on total outstanding memory requests. Legal values are powers of two, 2 or more.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request this cycle.
- `imem_req_addr` out `XLEN`: word-aligned fetch address; bits [1:0] always 0.
- `imem_resp_valid` in 1: response word valid. Responses return in request order, earliest one cycle after accept, and carry no backpressure.
- `imem_resp_data` in 32: instruction word.
- `wb_full` in 1: writeback retire queue full.
- `wb_next_id` in `INSTID_BITS`: free retire slot id; valid when `!wb_full`.
- `wb_inst_in` out 1: allocate a retire slot this cycle.
- `wb_inst_pc` out `XLEN`: PC of the allocated instruction.
- `flush_pipe_to_pc` in 1: writeback redirect pulse.
- `flush_pc` in `XLEN`: redirect target; bits [1:0] ignored.
- `dec_valid` out 1, `dec_ready` in 1: decode handshake.
- `dec_inst` out 32, `dec_pc` out `XLEN`, `dec_id` out `INSTID_BITS`: instruction, its PC, and its retire id.

## Operation
- State: `pc`, fetch queue (FIFO of {inst, pc}, count 0..`FQ_DEPTH`), `outstanding` (accepted requests without a response, including doomed ones), and `drop_cnt` (responses still to discard).
- A request is issued when `live + fq_count < FQ_DEPTH` and `outstanding < FQ_DEPTH` and `!flush_pipe_to_pc`, where `live = outstanding - drop_cnt`. In that case `imem_req_valid=1` and `imem_req_addr=pc`. This credit rule guarantees every live response has a queue slot, so overflow is impossible.
- When a request is accepted (`imem_req_valid && imem_req_ready`): `pc <= pc + 4` with modulo 2^XLEN wrap, and `outstanding++`.
- When a response arrives: `outstanding--`.
  - If `drop_cnt != 0`, the word is discarded and `drop_cnt--`.
  - Otherwise {data, pc of that request} is pushed to the queue. The PC is tracked by a parallel in-order PC FIFO, or by queue tail PC + 4.
- Issue: `dec_valid = fq_count != 0 && !wb_full && !flush_pipe_to_pc`.
  - `dec_inst` and `dec_pc` come from the queue head, and `dec_id = wb_next_id`.
  - `wb_inst_in = dec_valid && dec_ready`, with `wb_inst_pc = dec_pc`. On that cycle the queue pops.
- Flush (`flush_pipe_to_pc=1`) takes precedence over everything else:
  - `pc <= {flush_pc[XLEN-1:2], 2'b00}`.
  - The queue is cleared and no issue occurs.
  - `drop_cnt <= outstanding - (imem_resp_valid ? 1 : 0)`. Any response arriving on the flush cycle is itself discarded.
  - No request is issued in the flush cycle.
- Back-to-back flushes are legal. Each reloads `pc` and recomputes `drop_cnt` from the current `outstanding`.
- Simultaneous push and pop on a full queue is legal; the count is unchanged.

## Timing
- Reset (async assert, synchronous deassert handled upstream) sets:
  - `pc=RESET_PC`, `fq_count=0`, `outstanding=0`, `drop_cnt=0`.
  - Consequently `imem_req_valid=0`, `dec_valid=0`, `wb_inst_in=0`.
  - `imem_req_addr=RESET_PC`, and the data outputs are don't-care.
  - Reset mid-operation abandons all in-flight state. The memory is reset with the core.
- First request: the first cycle after `rst` deasserts.
- Response to `dec_valid`: a response pushed at edge N is visible on `dec_valid` from cycle N+1 (1-cycle queue latency). There is no combinational memory-to-decode path.
- Flush to new request: the flush is sampled at edge N, and a request to `flush_pc` is valid in cycle N+1 if credit allows.
- All outputs are combinational from registers, except:
  - `dec_valid`, `dec_id` and `wb_inst_in`, which depend on `wb_full`, `wb_next_id`, `dec_ready` and `flush_pipe_to_pc`.
  - `imem_req_valid`, which depends on `flush_pipe_to_pc`.
- Steady state with 1-cycle memory and `dec_ready=1`: one instruction per cycle.

## Test plan
- Reset with `RESET_PC=0x100` and 1-cycle memory returning addr^0xA5A5A5A5 -> requests 0x100, 0x104, 0x108 on consecutive cycles. Decode sees pc 0x100 three cycles after reset release, with the correct words and ids matching `wb_next_id` each cycle.
- `dec_ready=0` for 10 cycles -> the queue fills to `FQ_DEPTH` and requests stop, with no overflow and no lost words. On release, PCs continue in strict +4 order.
- `wb_full=1` with a non-empty queue -> `dec_valid=0` and `wb_inst_in=0`. Deasserting `wb_full` issues the head on the same cycle.
- Two requests outstanding under 3-cycle memory latency, then flush to 0x2003 -> both old responses are discarded. The next request is addr 0x2000 one cycle later, and the first decoded PC is 0x2000.
- Flush on the same cycle as a response and a `dec_ready` handshake -> no `wb_inst_in`, that response is discarded, and `drop_cnt` equals the remaining outstanding requests.
- `imem_req_ready` toggling randomly against a random-latency in-order memory model, with random flushes -> decoded PC stream matches a reference PC model, and `outstanding ≤ FQ_DEPTH` is never exceeded.
